dcache: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache for the 5-stage CPU's MEM stage.
//  - CPU side: consumes DATA_MEM_READ/WRITE/ADDR/WRITE_DATA; returns read data and busywait.
//  - Memory side: moves whole 128-bit blocks to and from main data memory.
//  - BUSYWAIT stalls the CPU pipeline on a miss.

---
 rtl/dcache.sv | 155 +++++++++++++++
 tb/tb_dcache.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-back write-allocate data cache (optional DCACHE_STATS_EN hit/miss counters)
module dcache #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [3:0]   READ,
    input  logic [2:0]   WRITE,
    input  logic [31:0]  ADDR,
    input  logic [31:0]  WRITE_DATA,
    output logic [31:0]  READ_DATA,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDR,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
`ifdef DCACHE_STATS_EN
    output logic [31:0]  HIT_COUNT,
    output logic [31:0]  MISS_COUNT,
`endif
    input  logic         MEM_BUSYWAIT
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q, dirty_q;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [127:0]            data_q [LINES];

    logic [INDEX_BITS-1:0]   idx;
    logic [TAG_W-1:0]        tag;
    logic                    req, write_req, hit;
    logic [127:0]            line, new_line;
    logic [31:0]             word, new_word, load_val;
    logic [7:0]              byte_v;
    logic [15:0]             half_v;

    assign idx       = ADDR[4 +: INDEX_BITS];
    assign tag       = ADDR[31 -: TAG_W];
    assign write_req = WRITE[2];
    assign req       = READ[3] | WRITE[2];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign line      = data_q[idx];
    assign word      = line[{ADDR[3:2], 5'b0} +: 32];
    assign byte_v    = word[{ADDR[1:0], 3'b0} +: 8];
    assign half_v    = word[{ADDR[1], 4'b0} +: 16];

    always_comb begin
        new_word = word;
        case (WRITE[1:0])
            2'b00:   new_word[{ADDR[1:0], 3'b0} +: 8] = WRITE_DATA[7:0];
            2'b01:   new_word[{ADDR[1], 4'b0} +: 16] = WRITE_DATA[15:0];
            default: new_word = WRITE_DATA;
        endcase
        new_line = line;
        new_line[{ADDR[3:2], 5'b0} +: 32] = new_word;
    end

    always_comb begin
        case (READ[2:0])
            3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_val = {{16{half_v[15]}}, half_v};
            3'b100:  load_val = {24'b0, byte_v};
            3'b101:  load_val = {16'b0, half_v};
            default: load_val = word;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req && !hit) state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
            WRITEBACK: if (!MEM_BUSYWAIT) state_d = FETCH;
            FETCH:     if (!MEM_BUSYWAIT) state_d = UPDATE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs are forced to their reset values while RESET is held low
    always_comb begin
        READ_DATA     = 32'b0;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDR      = 28'b0;
        MEM_WRITEDATA = 128'b0;
        if (RESET) begin
            READ_DATA = load_val;
            case (state_q)
                IDLE:      BUSYWAIT = req && !hit;
                WRITEBACK: begin
                    BUSYWAIT      = 1'b1;
                    MEM_WRITE     = 1'b1;
                    MEM_ADDR      = {tag_q[idx], idx};
                    MEM_WRITEDATA = line;
                end
                FETCH: begin
                    BUSYWAIT = 1'b1;
                    MEM_READ = 1'b1;
                    MEM_ADDR = ADDR[31:4];
                end
                default:   BUSYWAIT = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (state_q == UPDATE) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            tag_q[idx]   <= tag;
            data_q[idx]  <= MEM_READDATA;
        end else if (state_q == IDLE && write_req && hit) begin
            data_q[idx]  <= new_line;
            dirty_q[idx] <= 1'b1;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        missed_q;

    // missed_q marks the access that caused the miss so its eventual completion is not a hit
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            hit_cnt_q  <= 32'b0;
            miss_cnt_q <= 32'b0;
            missed_q   <= 1'b0;
        end else if (state_q == IDLE && req) begin
            if (hit) begin
                if (!missed_q && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
                missed_q <= 1'b0;
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
                missed_q <= 1'b1;
            end
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - directed self-checking bench for dcache
module tb_dcache;
    localparam int LAT = 2;

    logic         CLK, RESET;
    logic [3:0]   READ;
    logic [2:0]   WRITE;
    logic [31:0]  ADDR, WRITE_DATA, READ_DATA;
    logic         BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [27:0]  MEM_ADDR;
    logic [127:0] MEM_WRITEDATA, MEM_READDATA;
`ifdef DCACHE_STATS_EN
    logic [31:0]  HIT_COUNT, MISS_COUNT;
`endif

    dcache dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDR(ADDR),
        .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
`ifdef DCACHE_STATS_EN
        .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT),
`endif
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Main memory model: each request is held busy for LAT cycles, then completes
    logic [127:0] mem [256];
    int           cnt_q, rd_n, wr_n;
    logic [27:0]  wb_addr_q;
    logic [127:0] wb_data_q;

    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (cnt_q != LAT);

    initial begin
        cnt_q = 0; rd_n = 0; wr_n = 0;
        MEM_READDATA = '0; wb_addr_q = '0; wb_data_q = '0;
    end

    always @(posedge CLK) begin
        if (MEM_READ | MEM_WRITE) begin
            if (cnt_q == LAT) begin
                cnt_q <= 0;
                if (MEM_WRITE) begin
                    wb_addr_q <= MEM_ADDR;
                    wb_data_q <= MEM_WRITEDATA;
                    wr_n      <= wr_n + 1;
                end else begin
                    MEM_READDATA <= mem[MEM_ADDR[7:0]];
                    rd_n         <= rd_n + 1;
                end
            end else begin
                cnt_q <= cnt_q + 1;
            end
        end else begin
            cnt_q <= 0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a, input logic [31:0] wd);
        READ = rd; WRITE = wr; ADDR = a; WRITE_DATA = wd;
        #1;
    endtask

    task automatic wait_busy_low(input string tag, output int n);
        n = 0;
        while (BUSYWAIT !== 1'b0 && n < 30) begin
            tick;
            n++;
        end
        chk(tag, BUSYWAIT, 1'b0);
    endtask

    task automatic wait_mem_read(input string tag, output int n);
        n = 0;
        while (MEM_READ !== 1'b1 && n < 30) begin
            tick;
            n++;
        end
        chk(tag, MEM_READ, 1'b1);
    endtask

    localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010, LBU = 4'b1100, LHU = 4'b1101;
    localparam logic [3:0] NR = 4'b0000;
    localparam logic [2:0] SB = 3'b100, SH = 3'b101, SW = 3'b110, NW = 3'b000;

    initial begin
        int n1, n2, n3;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = {32'd4, 32'd3, 32'd2, 32'd1};
        mem[8'h18] = {32'h0, 32'h0, 32'h1234_5678, 32'h0000_80FF};

        RESET = 1'b0;
        drive(NR, NW, 32'h0, 32'h0);
        tick; tick;
        chk("rst_busywait", BUSYWAIT, 1'b0);
        chk("rst_mem_read", MEM_READ, 1'b0);
        chk("rst_mem_write", MEM_WRITE, 1'b0);
        chk("rst_mem_addr", MEM_ADDR, 28'h0);
        chk("rst_read_data", READ_DATA, 32'h0);
        chk("rst_mem_wdata", MEM_WRITEDATA, 128'h0);
`ifdef DCACHE_STATS_EN
        chk("rst_hits", HIT_COUNT, 32'd0);
        chk("rst_misses", MISS_COUNT, 32'd0);
`endif
        RESET = 1'b1;
        tick;
        chk("idle_no_req_busy", BUSYWAIT, 1'b0);

        // Clean miss on LW 0x100
        drive(LW, NW, 32'h100, 32'h0);
        chk("t1_miss_busy", BUSYWAIT, 1'b1);
        chk("t1_no_memread_idle", MEM_READ, 1'b0);
        tick;
        chk("t1_fetch_read", MEM_READ, 1'b1);
        chk("t1_fetch_write", MEM_WRITE, 1'b0);
        chk("t1_fetch_addr", MEM_ADDR, 28'h10);
        wait_busy_low("t1_done", n1);
        chk("t1_latency", 1 + n1, 5);
        chk("t1_data", READ_DATA, 32'h1);
        chk("t1_one_read", rd_n, 1);
        tick;
        drive(LW, NW, 32'h104, 32'h0);
        chk("t1_hit_busy", BUSYWAIT, 1'b0);
        chk("t1_hit_data", READ_DATA, 32'h2);
        tick;

        // Write hit then read back
        drive(NR, SW, 32'h108, 32'hDEAD_BEEF);
        chk("t2_store_busy", BUSYWAIT, 1'b0);
        tick;
        drive(LW, NW, 32'h108, 32'h0);
        chk("t2_load_busy", BUSYWAIT, 1'b0);
        chk("t2_load_data", READ_DATA, 32'hDEAD_BEEF);
        tick;

        // Dirty victim: writeback of block 0x10 then fetch of 0x18
        drive(LW, NW, 32'h180, 32'h0);
        chk("t3_miss_busy", BUSYWAIT, 1'b1);
        tick;
        chk("t3_wb_write", MEM_WRITE, 1'b1);
        chk("t3_wb_read", MEM_READ, 1'b0);
        chk("t3_wb_addr", MEM_ADDR, 28'h10);
        chk("t3_wb_word2", MEM_WRITEDATA[95:64], 32'hDEAD_BEEF);
        chk("t3_wb_word0", MEM_WRITEDATA[31:0], 32'h1);
        wait_mem_read("t3_fetch_start", n2);
        chk("t3_fetch_addr", MEM_ADDR, 28'h18);
        chk("t3_fetch_nowrite", MEM_WRITE, 1'b0);
        wait_busy_low("t3_done", n3);
        chk("t3_latency", 1 + n2 + n3, 8);
        chk("t3_wb_count", wr_n, 1);
        chk("t3_wb_cap_addr", wb_addr_q, 28'h10);
        chk("t3_wb_cap_word2", wb_data_q[95:64], 32'hDEAD_BEEF);
        chk("t3_data", READ_DATA, 32'h0000_80FF);
`ifdef DCACHE_STATS_EN
        chk("t6_misses", MISS_COUNT, 32'd2);
        chk("t6_hits", HIT_COUNT, 32'd3);
`endif
        tick;

        // Sign/zero extension on word 0x000080FF
        drive(LB, NW, 32'h180, 32'h0);  chk("t4_lb", READ_DATA, 32'hFFFF_FFFF);  tick;
        drive(LBU, NW, 32'h180, 32'h0); chk("t4_lbu", READ_DATA, 32'h0000_00FF); tick;
        drive(LH, NW, 32'h180, 32'h0);  chk("t4_lh", READ_DATA, 32'hFFFF_80FF);  tick;
        drive(LHU, NW, 32'h180, 32'h0); chk("t4_lhu", READ_DATA, 32'h0000_80FF); tick;
        drive(LB, NW, 32'h181, 32'h0);  chk("t4_lb_b1", READ_DATA, 32'hFFFF_FF80); tick;
        drive(LHU, NW, 32'h182, 32'h0); chk("t4_lhu_h1", READ_DATA, 32'h0); tick;
        drive(LH, NW, 32'h185, 32'h0);  chk("t4_lh_misalign", READ_DATA, 32'h0000_5678); tick;

        // Reset during a fetch
        drive(LW, NW, 32'h100, 32'h0);
        chk("t5_miss_busy", BUSYWAIT, 1'b1);
        tick;
        chk("t5_fetch_read", MEM_READ, 1'b1);
        chk("t5_fetch_membusy", MEM_BUSYWAIT, 1'b1);
        RESET = 1'b0;
        tick;
        chk("t5_rst_read", MEM_READ, 1'b0);
        chk("t5_rst_busy", BUSYWAIT, 1'b0);
        RESET = 1'b1;
        #1;
        chk("t5_remiss_busy", BUSYWAIT, 1'b1);
        tick;
        chk("t5_refetch_read", MEM_READ, 1'b1);
        chk("t5_refetch_addr", MEM_ADDR, 28'h10);
        wait_busy_low("t5_done", n1);
        chk("t5_data", READ_DATA, 32'h1);
        chk("t5_read_count", rd_n, 3);
        tick;

        // Sub-word stores
        drive(NR, SH, 32'h106, 32'h1234_CAFE); chk("sh_busy", BUSYWAIT, 1'b0); tick;
        drive(LW, NW, 32'h104, 32'h0);         chk("sh_data", READ_DATA, 32'hCAFE_0002); tick;
        drive(NR, SB, 32'h101, 32'hFFFF_FF77); tick;
        drive(LW, NW, 32'h100, 32'h0);         chk("sb_data", READ_DATA, 32'h0000_7701); tick;
        drive(NR, NW, 32'h0, 32'h0);
        chk("final_idle_busy", BUSYWAIT, 1'b0);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
